// File: rtl/jtag_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_debug_ocimem_ctrl
//
// Purpose: debug-monitor memory controller behind the JTAG debug-module
// wrapper. It decodes the wrapper's ocimem action strobes and the jdo word.
// From these it runs single-word reads and writes on the debug memory port.
// It returns MonDReg, monitor_ready and monitor_error so the wrapper can
// shift them back to the host.
//
// Parameters:
//   TIMEOUT                 stalled cycles tolerated before an abort (1..65535)
//
// Ports:
//   clk                     system clock
//   reset_n                 asynchronous active-low reset
//   jdo[37:0]               wrapper data word, sampled only with a strobe
//   take_action_ocimem_a    load address (jdo[33:26]); jdo[34] clears the
//                           error flag; jdo[35] also starts a read
//   take_action_ocimem_b    write jdo[34:3] at the current address
//   take_no_action_ocimem_a read at the current address
//   mem_address/read/write/writedata  debug memory request (registered)
//   mem_readdata, mem_waitrequest     debug memory response
//   MonDReg                 monitor data register
//   monitor_ready           last access finished, block idle
//   monitor_error           sticky error (timeout or overrun)
// ---------------------------------------------------------------------------
module jtag_debug_ocimem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [7:0]  mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [15:0] W_TIMEOUT = 16'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_mon_areg;
  logic [31:0] r_mon_dreg;
  logic [7:0]  r_mem_address;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_writedata;
  logic        r_monitor_ready;
  logic        r_monitor_error;
  logic [15:0] r_wait_cnt;

  logic        w_strobe_any;
  logic        w_unused_jdo;

  assign w_strobe_any = take_action_ocimem_a | take_action_ocimem_b
                      | take_no_action_ocimem_a;

  // jdo bits that carry no meaning for this block
  assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Control FSM: strobe decode, memory handshake, timeout and error tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_mon_areg      <= 8'h00;
      r_mon_dreg      <= 32'h0000_0000;
      r_mem_address   <= 8'h00;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_writedata <= 32'h0000_0000;
      r_monitor_ready <= 1'b0;
      r_monitor_error <= 1'b0;
      r_wait_cnt      <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Priority: action_a > action_b > no_action_a
          if (take_action_ocimem_a) begin
            r_mon_areg <= jdo[33:26];
            if (jdo[34]) begin
              r_monitor_error <= 1'b0;
            end
            if (jdo[35]) begin
              r_mem_address   <= jdo[33:26];
              r_mem_read      <= 1'b1;
              r_monitor_ready <= 1'b0;
              r_state         <= ST_READ;
            end
          end else if (take_action_ocimem_b) begin
            r_mon_dreg      <= jdo[34:3];
            r_mem_writedata <= jdo[34:3];
            r_mem_address   <= r_mon_areg;
            r_mem_write     <= 1'b1;
            r_monitor_ready <= 1'b0;
            r_state         <= ST_WRITE;
          end else if (take_no_action_ocimem_a) begin
            r_mem_address   <= r_mon_areg;
            r_mem_read      <= 1'b1;
            r_monitor_ready <= 1'b0;
            r_state         <= ST_READ;
          end
        end

        ST_READ, ST_WRITE: begin
          // A strobe during an access is dropped but flagged
          if (w_strobe_any) begin
            r_monitor_error <= 1'b1;
          end
          if (!mem_waitrequest) begin
            if (r_state == ST_READ) begin
              r_mon_dreg <= mem_readdata;
            end
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mon_areg      <= r_mon_areg + 8'd1;
            r_monitor_ready <= 1'b1;
            r_wait_cnt      <= 16'h0000;
            r_state         <= ST_IDLE;
          end else if (r_wait_cnt == W_TIMEOUT) begin
            // Counter hits TIMEOUT on the (TIMEOUT+1)-th request cycle
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_monitor_error <= 1'b1;
            r_monitor_ready <= 1'b1;
            r_wait_cnt      <= 16'h0000;
            r_state         <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end

        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_wait_cnt  <= 16'h0000;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_address   = r_mem_address;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_writedata = r_mem_writedata;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_monitor_ready;
  assign monitor_error = r_monitor_error;

endmodule

// File: tb/tb_jtag_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jtag_debug_ocimem_ctrl
//
// Directed bench for jtag_debug_ocimem_ctrl with TIMEOUT = 4. A small memory
// array answers the debug port. Inputs change and outputs are sampled 1 ns
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_jtag_debug_ocimem_ctrl;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  logic [31:0] tb_mem [256];
  int          n_checks;
  int          n_errors;

  jtag_debug_ocimem_ctrl #(.TIMEOUT(4)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_readdata            (mem_readdata),
    .mem_waitrequest         (mem_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // Clock: 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read, write on an accepted write cycle
  assign mem_readdata = tb_mem[mem_address];

  always @(posedge clk) begin
    if (mem_write && !mem_waitrequest) begin
      tb_mem[mem_address] <= mem_writedata;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic clr,
                          input logic rd);
    jdo = {2'b00, rd, clr, addr, 26'h0};
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = {3'b000, data, 3'b000};
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic strobe_n();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'h5A00_0000 | 32'(i);
    end
    tb_mem[8'h10] = 32'hDEAD_BEEF;
    tb_mem[8'h11] = 32'h1111_0011;
    tb_mem[8'h30] = 32'hCAFE_F00D;
    tb_mem[8'h31] = 32'h3131_3131;
    tb_mem[8'h42] = 32'h600D_CAFE;

    reset_n                 = 1'b0;
    jdo                     = 38'h0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_waitrequest         = 1'b0;
    tick();
    tick();

    // Reset state
    check_val("rst_ready",   32'(monitor_ready), 32'h0);
    check_val("rst_error",   32'(monitor_error), 32'h0);
    check_val("rst_mondreg", MonDReg,            32'h0);
    check_val("rst_read",    32'(mem_read),      32'h0);
    check_val("rst_write",   32'(mem_write),     32'h0);
    check_val("rst_wdata",   mem_writedata,      32'h0);
    check_val("rst_addr",    32'(mem_address),   32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Address-load read at 0x10
    strobe_a(8'h10, 1'b0, 1'b1);
    check_val("t1_read_hi",  32'(mem_read),      32'h1);
    check_val("t1_addr",     32'(mem_address),   32'h10);
    check_val("t1_ready_lo", 32'(monitor_ready), 32'h0);
    tick();
    check_val("t1_read_lo",  32'(mem_read),      32'h0);
    check_val("t1_mondreg",  MonDReg,            32'hDEAD_BEEF);
    check_val("t1_ready",    32'(monitor_ready), 32'h1);
    strobe_n();
    check_val("t1_inc_addr", 32'(mem_address),   32'h11);
    tick();
    check_val("t1_inc_data", MonDReg,            32'h1111_0011);

    // Write then auto-increment read
    strobe_a(8'h20, 1'b0, 1'b0);
    check_val("t2_noread",   32'(mem_read),      32'h0);
    strobe_b(32'h1234_5678);
    check_val("t2_write_hi", 32'(mem_write),     32'h1);
    check_val("t2_waddr",    32'(mem_address),   32'h20);
    check_val("t2_wdata",    mem_writedata,      32'h1234_5678);
    check_val("t2_mondreg",  MonDReg,            32'h1234_5678);
    tick();
    check_val("t2_write_lo", 32'(mem_write),     32'h0);
    check_val("t2_ready",    32'(monitor_ready), 32'h1);
    check_val("t2_memword",  tb_mem[8'h20],      32'h1234_5678);
    strobe_n();
    check_val("t2_raddr",    32'(mem_address),   32'h21);
    check_val("t2_read_hi",  32'(mem_read),      32'h1);
    tick();

    // Wait states: 3 stalled cycles
    mem_waitrequest = 1'b1;
    strobe_a(8'h30, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_val("t3_read_hold", 32'(mem_read),      32'h1);
      check_val("t3_addr_hold", 32'(mem_address),   32'h30);
      check_val("t3_ready_lo",  32'(monitor_ready), 32'h0);
      if (i == 3) begin
        mem_waitrequest = 1'b0;
      end
      tick();
    end
    check_val("t3_read_lo",  32'(mem_read),      32'h0);
    check_val("t3_ready",    32'(monitor_ready), 32'h1);
    check_val("t3_error",    32'(monitor_error), 32'h0);
    check_val("t3_mondreg",  MonDReg,            32'hCAFE_F00D);

    // Timeout (TIMEOUT = 4) with waitrequest stuck high
    mem_waitrequest = 1'b1;
    strobe_n();
    check_val("t4_addr",     32'(mem_address),   32'h31);
    cnt = 0;
    while (mem_read && cnt < 20) begin
      cnt = cnt + 1;
      tick();
    end
    check_val("t4_req_cycles", 32'(cnt),         32'd5);
    check_val("t4_error",    32'(monitor_error), 32'h1);
    check_val("t4_ready",    32'(monitor_ready), 32'h1);
    check_val("t4_mondreg",  MonDReg,            32'hCAFE_F00D);
    mem_waitrequest = 1'b0;
    strobe_n();
    check_val("t4_areg_kept", 32'(mem_address),  32'h31);
    tick();
    check_val("t4_retry_data", MonDReg,          32'h3131_3131);
    check_val("t4_err_sticky", 32'(monitor_error), 32'h1);
    strobe_a(8'h40, 1'b1, 1'b0);
    check_val("t4_err_clear", 32'(monitor_error), 32'h0);

    // Wrap at 0xFF and overrun during a stalled write
    strobe_a(8'hFF, 1'b0, 1'b0);
    mem_waitrequest = 1'b1;
    strobe_b(32'h0BAD_F00D);
    check_val("t5_write_hi", 32'(mem_write),     32'h1);
    check_val("t5_waddr",    32'(mem_address),   32'hFF);
    strobe_b(32'h1111_1111);
    check_val("t5_ovr_error", 32'(monitor_error), 32'h1);
    check_val("t5_ovr_wdata", mem_writedata,     32'h0BAD_F00D);
    check_val("t5_ovr_mond",  MonDReg,           32'h0BAD_F00D);
    strobe_a(8'h55, 1'b1, 1'b1);
    check_val("t5_ovr_noclr", 32'(monitor_error), 32'h1);
    check_val("t5_ovr_addr",  32'(mem_address),  32'hFF);
    check_val("t5_ovr_write", 32'(mem_write),    32'h1);
    mem_waitrequest = 1'b0;
    tick();
    check_val("t5_write_lo", 32'(mem_write),     32'h0);
    check_val("t5_ready",    32'(monitor_ready), 32'h1);
    check_val("t5_memword",  tb_mem[8'hFF],      32'h0BAD_F00D);
    strobe_n();
    check_val("t5_wrap_addr", 32'(mem_address),  32'h00);
    tick();
    check_val("t5_wrap_data", MonDReg,           32'h5A00_0000);

    // Reset during a stalled write
    mem_waitrequest = 1'b1;
    strobe_b(32'h7777_7777);
    check_val("t6_write_hi", 32'(mem_write),     32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("t6_write_drop", 32'(mem_write),   32'h0);
    check_val("t6_read",     32'(mem_read),      32'h0);
    check_val("t6_addr",     32'(mem_address),   32'h0);
    check_val("t6_wdata",    mem_writedata,      32'h0);
    check_val("t6_mondreg",  MonDReg,            32'h0);
    check_val("t6_ready",    32'(monitor_ready), 32'h0);
    check_val("t6_error",    32'(monitor_error), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    tick();
    strobe_a(8'h42, 1'b0, 1'b1);
    check_val("t6_post_read", 32'(mem_read),     32'h1);
    check_val("t6_post_addr", 32'(mem_address),  32'h42);
    tick();
    check_val("t6_post_data", MonDReg,           32'h600D_CAFE);
    check_val("t6_post_ready", 32'(monitor_ready), 32'h1);
    check_val("t6_post_error", 32'(monitor_error), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtag_debug_ocimem_ctrl.md
# jtag_debug_ocimem_ctrl

JTAG debug monitor memory controller; sits directly downstream of the Nios II JTAG debug-module wrapper in the `clk` domain. It consumes the wrapper's `jdo` word and its `ocimem` action strobes, then runs single-word reads and writes on a debug memory port. It returns `MonDReg`, `monitor_ready` and `monitor_error`, which the wrapper shifts back to the host over JTAG.

## Interface
- `TIMEOUT`, default 255: maximum number of consecutive cycles with `mem_waitrequest` high before the access is aborted. Legal range 1..65535.
- `clk` input, 1: system clock, the single clock of the block.
- `reset_n` input, 1: asynchronous, active-low reset.
- `jdo` input, 38: debug data word from the wrapper; sampled only in a strobe cycle.
- `take_action_ocimem_a` input, 1: one-cycle strobe; load address and optionally start a read.
- `take_action_ocimem_b` input, 1: one-cycle strobe; write data at the current address.
- `take_no_action_ocimem_a` input, 1: one-cycle strobe; read at the current address.
- `mem_address` output, 8: word address to debug memory.
- `mem_read` output, 1: read request.
- `mem_write` output, 1: write request.
- `mem_writedata` output, 32: write data.
- `mem_readdata` input, 32: read data; valid when `mem_read` is high and `mem_waitrequest` is low.
- `mem_waitrequest` input, 1: slave stall.
- `MonDReg` output, 32: monitor data register.
- `monitor_ready` output, 1: last access finished and the block is idle.
- `monitor_error` output, 1: sticky error flag.

## Operation
- **FSM states:** IDLE, READ, WRITE. All outputs are registered.
- **Reset values:**
  - FSM = IDLE.
  - `MonAReg` (internal address) = 0.
  - `MonDReg` = 0, `mem_writedata` = 0, `mem_address` = 0.
  - `mem_read` = 0, `mem_write` = 0.
  - `monitor_ready` = 0, `monitor_error` = 0.
  - Timeout counter = 0.
- **Strobe priority:** `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Only the highest-priority strobe in a cycle is acted on.
- **In IDLE:**
  - `take_action_ocimem_a`:
    - `MonAReg <= jdo[33:26]`.
    - If `jdo[34]`, clear `monitor_error`.
    - If `jdo[35]`, start a READ at `jdo[33:26]`.
  - `take_action_ocimem_b`:
    - `MonDReg <= jdo[34:3]`, `mem_writedata <= jdo[34:3]`.
    - Start a WRITE at `MonAReg`.
  - `take_no_action_ocimem_a`: start a READ at `MonAReg`.
  - Starting any access clears `monitor_ready`, drives `mem_address` and asserts `mem_read` or `mem_write`.
- **In READ or WRITE:**
  - Hold the request and address stable while `mem_waitrequest` = 1. Increment the timeout counter each stalled cycle.
  - **Completion** is the first cycle with `mem_waitrequest` = 0. On completion:
    - READ only: `MonDReg <= mem_readdata`.
    - Deassert the request.
    - `MonAReg <= MonAReg + 1`, modulo 256 (255 wraps to 0).
    - Set `monitor_ready`, clear the counter, return to IDLE.
  - **Timeout:** when the counter reaches `TIMEOUT` with `mem_waitrequest` still 1:
    - Deassert the request.
    - `monitor_error <= 1`, `monitor_ready <= 1`.
    - `MonDReg` and `MonAReg` unchanged.
    - Clear the counter, return to IDLE.
- **Overrun:** any strobe arriving while not in IDLE is ignored entirely (including a `jdo[34]` clear) and sets `monitor_error`. The in-flight access continues unaffected.
- `monitor_error` clears only through `take_action_ocimem_a` with `jdo[34]` = 1 in IDLE, or through reset.
- **Reset mid-access:** all registers return to their reset values immediately; the request drops asynchronously.

## Timing
- Strobe in cycle N → request asserted from cycle N+1.
- With no stall, read data is in `MonDReg` and `monitor_ready` = 1 at cycle N+2.
- Access latency is 2 + (number of stall cycles).
- The earliest next accepted strobe is in cycle N+2, the cycle `monitor_ready` rises.
- On timeout, the request is high for exactly `TIMEOUT` + 1 cycles.
- Throughput is one access per 2 cycles minimum.

## Test plan
- **Address-load read:**
  - Stimulus: `take_action_ocimem_a` with `jdo[33:26]` = 0x10, `jdo[35]` = 1; memory word 0x10 = 0xDEADBEEF; no stall.
  - Required: `mem_read` high for 1 cycle with address 0x10; `MonDReg` = 0xDEADBEEF and `monitor_ready` = 1 at N+2; `MonAReg` = 0x11.
- **Write then auto-increment read:**
  - Stimulus: load address 0x20 without a read; `take_action_ocimem_b` with `jdo[34:3]` = 0x12345678; then `take_no_action_ocimem_a`.
  - Required: write of 0x12345678 to address 0x20; read issued at address 0x21.
- **Wait-state handling:**
  - Stimulus: `mem_waitrequest` held high for 3 cycles on a read.
  - Required: request and address stable for 4 cycles; `monitor_ready` = 1 at N+5; `monitor_error` = 0.
- **Timeout and error clear:**
  - Stimulus: `TIMEOUT` = 4; `mem_waitrequest` stuck high.
  - Required: request high 5 cycles; `monitor_error` = 1; `MonDReg` and `MonAReg` unchanged.
  - Follow-up: `take_action_ocimem_a` with `jdo[34]` = 1 → `monitor_error` = 0.
- **Wrap and overrun:**
  - Stimulus: write at address 0xFF; issue a strobe while the write is stalled.
  - Required: `MonAReg` = 0x00 after completion; `monitor_error` = 1; the stalled write completes with its original data.
- **Reset mid-access:**
  - Stimulus: assert `reset_n` = 0 during a stalled WRITE.
  - Required: `mem_write` drops at once; all outputs at reset values; the first strobe after release operates normally.
